// File: rtl/alu_operand_stage.sv
// ID/EX register with RAW forwarding from EX/MEM and MEM/WB, feeding the execute ALU.
// A held instruction refreshes its operands from the forwarding network while stalled.

module alu_operand_fwd #(
  parameter int XLEN = 32,
  parameter int RA   = 5
) (
  input  logic [RA-1:0]   i_rs,
  input  logic [XLEN-1:0] i_held,
  input  logic [RA-1:0]   i_exm_rd,
  input  logic            i_exm_regwrite,
  input  logic [XLEN-1:0] i_exm_result,
  input  logic [RA-1:0]   i_mwb_rd,
  input  logic            i_mwb_regwrite,
  input  logic [XLEN-1:0] i_mwb_result,
  output logic [XLEN-1:0] o_val
);
  logic w_nz, w_hit_exm, w_hit_mwb;

  assign w_nz      = |i_rs;
  assign w_hit_exm = w_nz & i_exm_regwrite & (i_exm_rd == i_rs);
  assign w_hit_mwb = w_nz & i_mwb_regwrite & (i_mwb_rd == i_rs);

  // The younger producer (EX/MEM) takes precedence.
  always_comb begin
    o_val = i_held;
    if (w_hit_exm)      o_val = i_exm_result;
    else if (w_hit_mwb) o_val = i_mwb_result;
  end
endmodule

module alu_operand_stage #(
  parameter int XLEN = 32,
  parameter int RA   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA-1:0]   rs1_in,
  input  logic [RA-1:0]   rs2_in,
  input  logic [RA-1:0]   rd_in,
  input  logic [XLEN-1:0] rd1_in,
  input  logic [XLEN-1:0] rd2_in,
  input  logic [XLEN-1:0] immext_in,
  input  logic            alusrc_in,
  input  logic [2:0]      alucontrol_in,
  input  logic            regwrite_in,
  input  logic            flush,
  input  logic [RA-1:0]   exm_rd,
  input  logic            exm_regwrite,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA-1:0]   mwb_rd,
  input  logic            mwb_regwrite,
  input  logic [XLEN-1:0] mwb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] srca,
  output logic [XLEN-1:0] srcb,
  output logic [2:0]      alucontrol,
  output logic [RA-1:0]   rd_out,
  output logic            regwrite_out,
  output logic [XLEN-1:0] writedata
);
  localparam int NSRC = 2;

  typedef struct packed {
    logic [RA-1:0]   rs1;
    logic [RA-1:0]   rs2;
    logic [RA-1:0]   rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [2:0]      aluctl;
    logic            regwrite;
  } id_ex_t;

  id_ex_t r_q;
  logic   r_valid;
  id_ex_t w_in;
  logic   w_capture, w_consume, w_stall;

  logic [NSRC-1:0][RA-1:0]   w_rs;
  logic [NSRC-1:0][XLEN-1:0] w_held;
  logic [NSRC-1:0][XLEN-1:0] w_fwd;

  assign w_in = '{rs1: rs1_in, rs2: rs2_in, rd: rd_in, rd1: rd1_in, rd2: rd2_in,
                  imm: immext_in, alusrc: alusrc_in, aluctl: alucontrol_in,
                  regwrite: regwrite_in};

  assign in_ready  = ~r_valid | out_ready;
  assign w_capture = in_valid & in_ready & ~flush;
  assign w_consume = r_valid & out_ready;
  assign w_stall   = r_valid & ~out_ready & ~flush;

  assign w_rs   = {r_q.rs2, r_q.rs1};
  assign w_held = {r_q.rd2, r_q.rd1};

  for (genvar g = 0; g < NSRC; g++) begin : g_fwd
    alu_operand_fwd #(.XLEN(XLEN), .RA(RA)) u_fwd (
      .i_rs           (w_rs[g]),
      .i_held         (w_held[g]),
      .i_exm_rd       (exm_rd),
      .i_exm_regwrite (exm_regwrite),
      .i_exm_result   (exm_result),
      .i_mwb_rd       (mwb_rd),
      .i_mwb_regwrite (mwb_regwrite),
      .i_mwb_result   (mwb_result),
      .o_val          (w_fwd[g])
    );
  end

  // Stalled operands are re-latched from the forwarding network so that a
  // value survives its producer leaving EX/MEM or MEM/WB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_q     <= w_in;
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end else if (w_stall) begin
      r_q.rd1 <= w_fwd[0];
      r_q.rd2 <= w_fwd[1];
    end
  end

  assign out_valid    = r_valid;
  assign srca         = w_fwd[0];
  assign writedata    = w_fwd[1];
  assign srcb         = r_q.alusrc ? r_q.imm : w_fwd[1];
  assign alucontrol   = r_q.aluctl;
  assign rd_out       = r_q.rd;
  assign regwrite_out = r_q.regwrite & r_valid;
endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios followed by randomized traffic
// checked against an instruction-level reference model.

module tb_alu_operand_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic [31:0] rd1_in, rd2_in, immext_in;
  logic        alusrc_in;
  logic [2:0]  alucontrol_in;
  logic        regwrite_in, flush;
  logic [4:0]  exm_rd, mwb_rd;
  logic        exm_regwrite, mwb_regwrite;
  logic [31:0] exm_result, mwb_result;
  logic        out_valid, out_ready;
  logic [31:0] srca, srcb, writedata;
  logic [2:0]  alucontrol;
  logic [4:0]  rd_out;
  logic        regwrite_out;

  int n_tests = 0;
  int n_fail  = 0;

  alu_operand_stage #(.XLEN(32), .RA(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .rd1_in(rd1_in), .rd2_in(rd2_in), .immext_in(immext_in),
    .alusrc_in(alusrc_in), .alucontrol_in(alucontrol_in), .regwrite_in(regwrite_in),
    .flush(flush),
    .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
    .mwb_rd(mwb_rd), .mwb_regwrite(mwb_regwrite), .mwb_result(mwb_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .rd_out(rd_out),
    .regwrite_out(regwrite_out), .writedata(writedata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; rs1_in = 0; rs2_in = 0; rd_in = 0; rd1_in = 0; rd2_in = 0;
    immext_in = 0; alusrc_in = 0; alucontrol_in = 0; regwrite_in = 0; flush = 0;
    exm_rd = 0; exm_regwrite = 0; exm_result = 0;
    mwb_rd = 0; mwb_regwrite = 0; mwb_result = 0; out_ready = 0;
  endtask

  // Reference: one held instruction (or none), operands resolved by register name.
  typedef struct {
    bit          v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] a, b, imm;
    bit          use_imm;
    logic [2:0]  op;
    bit          wr;
  } instr_t;

  instr_t m;

  function automatic logic [31:0] ref_val(logic [4:0] r, logic [31:0] held);
    if (r == 0) return held;
    if (exm_regwrite && exm_rd == r) return exm_result;
    if (mwb_regwrite && mwb_rd == r) return mwb_result;
    return held;
  endfunction

  task automatic model_check(input int cyc);
    logic [31:0] ea, eb;
    ea = ref_val(m.rs1, m.a);
    eb = ref_val(m.rs2, m.b);
    chk("rnd_out_valid", {31'b0, out_valid}, {31'b0, m.v});
    chk("rnd_in_ready", {31'b0, in_ready}, {31'b0, !m.v || out_ready});
    chk("rnd_regwrite_out", {31'b0, regwrite_out}, {31'b0, m.v && m.wr});
    if (m.v) begin
      chk("rnd_srca", srca, ea);
      chk("rnd_writedata", writedata, eb);
      chk("rnd_srcb", srcb, m.use_imm ? m.imm : eb);
      chk("rnd_alucontrol", {29'b0, alucontrol}, {29'b0, m.op});
      chk("rnd_rd_out", {27'b0, rd_out}, {27'b0, m.rd});
    end
    if (n_fail > 0 && cyc < 0) $display("cycle %0d", cyc);
  endtask

  task automatic model_step();
    bit rdy;
    rdy = !m.v || out_ready;
    if (flush) m.v = 0;
    else if (in_valid && rdy) begin
      m.v = 1; m.rs1 = rs1_in; m.rs2 = rs2_in; m.rd = rd_in;
      m.a = rd1_in; m.b = rd2_in; m.imm = immext_in; m.use_imm = alusrc_in;
      m.op = alucontrol_in; m.wr = regwrite_in;
    end else if (m.v && out_ready) m.v = 0;
    else if (m.v) begin
      logic [31:0] na, nb;
      na = ref_val(m.rs1, m.a);
      nb = ref_val(m.rs2, m.b);
      m.a = na; m.b = nb;
    end
  endtask

  logic [31:0] imms [4];
  logic [2:0]  ops [5];

  initial begin
    ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b101};
    idle();
    reset = 0;
    #12;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_regwrite_out", {31'b0, regwrite_out}, 32'd0);
    chk("reset_srca", srca, 32'd0);
    chk("reset_srcb", srcb, 32'd0);
    chk("reset_writedata", writedata, 32'd0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); reset = 1;

    // simple capture, no forwarding
    in_valid = 1; rs1_in = 1; rs2_in = 2; rd_in = 4; rd1_in = 5; rd2_in = 7;
    alucontrol_in = 3'b000; regwrite_in = 1;
    @(posedge clk); #1;
    chk("cap_out_valid", {31'b0, out_valid}, 32'd1);
    chk("cap_srca", srca, 32'd5);
    chk("cap_srcb", srcb, 32'd7);
    chk("cap_alucontrol", {29'b0, alucontrol}, 32'd0);
    chk("cap_regwrite_out", {31'b0, regwrite_out}, 32'd1);

    // forwarding priority on rs1=3
    @(negedge clk);
    out_ready = 1; rs1_in = 3; rd1_in = 32'h99;
    @(negedge clk);
    in_valid = 0; out_ready = 0;
    exm_rd = 3; exm_regwrite = 1; exm_result = 32'h10;
    mwb_rd = 3; mwb_regwrite = 1; mwb_result = 32'h20;
    #1 chk("fwd_exm_wins", srca, 32'h10);
    exm_regwrite = 0;
    #1 chk("fwd_mwb", srca, 32'h20);

    // x0 is never forwarded
    @(negedge clk);
    out_ready = 1; in_valid = 1; rs1_in = 0; rd1_in = 32'h33;
    exm_rd = 0; exm_regwrite = 1; mwb_rd = 0; mwb_regwrite = 1;
    @(posedge clk); #1;
    chk("fwd_x0_held", srca, 32'h33);
    @(negedge clk);
    idle(); out_ready = 1;
    @(posedge clk); #1;
    chk("drain_out_valid", {31'b0, out_valid}, 32'd0);

    // stall refresh keeps a forwarded value after its producer retires
    @(negedge clk);
    in_valid = 1; rs1_in = 1; rd1_in = 1; rs2_in = 2; rd2_in = 32'h11; alusrc_in = 0;
    out_ready = 0;
    @(negedge clk);
    in_valid = 0; mwb_rd = 2; mwb_regwrite = 1; mwb_result = 32'hAB;
    #1 chk("stall_srcb_fwd", srcb, 32'hAB);
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    mwb_regwrite = 0;
    #1 chk("stall_srcb_kept", srcb, 32'hAB);
    chk("stall_wdata_kept", writedata, 32'hAB);
    @(negedge clk);
    out_ready = 1;
    #1 chk("stall_release_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("stall_consumed", {31'b0, out_valid}, 32'd0);

    // back-to-back with immediates
    for (int i = 0; i < 4; i++) imms[i] = $urandom;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1; out_ready = 1; alusrc_in = 1; immext_in = imms[i];
      @(posedge clk); #1;
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_srcb", srcb, imms[i]);
    end
    @(negedge clk); in_valid = 0;
    @(posedge clk); #1;
    chk("b2b_drain", {31'b0, out_valid}, 32'd0);

    // flush while holding, with a new instruction offered
    @(negedge clk);
    idle(); in_valid = 1; regwrite_in = 1; rd_in = 7;
    @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_regwrite_out", {31'b0, regwrite_out}, 32'd0);

    // async reset mid-stall
    @(negedge clk);
    flush = 0; in_valid = 1; out_ready = 0;
    @(negedge clk);
    in_valid = 0;
    chk("pre_areset_valid", {31'b0, out_valid}, 32'd1);
    #2 reset = 0;
    #1 chk("areset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("areset_regwrite_out", {31'b0, regwrite_out}, 32'd0);

    // randomized traffic against the reference model
    @(negedge clk); reset = 1; idle();
    m = '{default: '0};
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      in_valid      = ($urandom_range(0, 3) != 0);
      rs1_in        = 5'($urandom_range(0, 3));
      rs2_in        = 5'($urandom_range(0, 3));
      rd_in         = 5'($urandom);
      rd1_in        = $urandom;
      rd2_in        = $urandom;
      immext_in     = $urandom;
      alusrc_in     = 1'($urandom);
      alucontrol_in = ops[$urandom_range(0, 4)];
      regwrite_in   = 1'($urandom);
      flush         = ($urandom_range(0, 15) == 0);
      out_ready     = 1'($urandom);
      exm_rd        = 5'($urandom_range(0, 3));
      exm_regwrite  = 1'($urandom);
      exm_result    = $urandom;
      mwb_rd        = 5'($urandom_range(0, 3));
      mwb_regwrite  = 1'($urandom);
      mwb_result    = $urandom;
      #1 model_check(c);
      model_step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
